bootrom_arbiter: RTL and testbench

//  Round-robin arbiter and sequencer that shares the single-port mask BootROM (11-bit word address,
//  32-bit data, 1-cycle registered read, tri-stated q gated by oe) between two requesters: port 0 =

---
 rtl/bootrom_pkg.sv | 9 +
 rtl/rr_arbiter2.sv | 15 +
 rtl/bootrom_arbiter.sv | 81 ++++++++
 tb/tb_bootrom_arbiter.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/bootrom_pkg.sv
// bootrom_pkg: shared state encoding, default widths and address legality check for the BootROM arbiter
package bootrom_pkg;
  typedef enum logic [1:0] {IDLE, READ, RESP} state_t;
  localparam int DEF_ROM_AW = 11;
  localparam int DEF_DATA_W = 32;
  function automatic logic addr_legal(input logic [31:0] addr, input int rom_words);
    return (addr[1:0] == 2'b00) && ({2'b00, addr[31:2]} < 32'(rom_words));
  endfunction
endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin grant with a pointer that flips away from the last winner
module rr_arbiter2 (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] valid,
  input  logic       take,
  output logic       grant
);
  logic ptr;
  assign grant = valid[ptr] ? ptr : ~ptr;
  // pointer moves to the port that lost, so a waiting port wins next time
  always_ff @(posedge clock)
    if (reset) ptr <= 1'b0;
    else if (take) ptr <= ~grant;
endmodule

// File: rtl/bootrom_arbiter.sv
// bootrom_arbiter: shares a single-port registered BootROM between two requesters, one access at a time
module bootrom_arbiter
  import bootrom_pkg::*;
#(
  parameter int ROM_AW    = DEF_ROM_AW,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int BYTE_AW   = ROM_AW + 2,
  parameter int ROM_WORDS = 2 ** ROM_AW
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [1:0]           req_valid,
  output logic [1:0]           req_ready,
  input  logic [2*BYTE_AW-1:0] req_addr,
  output logic [1:0]           resp_valid,
  input  logic [1:0]           resp_ready,
  output logic [DATA_W-1:0]    resp_data,
  output logic                 resp_err,
  output logic                 rom_me,
  output logic                 rom_oe,
  output logic [ROM_AW-1:0]    rom_address,
  input  logic [DATA_W-1:0]    rom_q
);
  state_t state, nxt;
  logic grant, owner, take, legal;
  logic [BYTE_AW-1:0] sel_addr;
  assign take     = (state == IDLE) && !reset && (|req_valid);
  assign sel_addr = grant ? req_addr[2*BYTE_AW-1:BYTE_AW] : req_addr[BYTE_AW-1:0];
  assign legal    = addr_legal(32'(sel_addr), ROM_WORDS);
  rr_arbiter2 u_rr (
    .clock(clock),
    .reset(reset),
    .valid(req_valid),
    .take (take),
    .grant(grant)
  );
  // next state plus ROM strobes and handshakes; rom_me only in the grant cycle, rom_oe only in READ
  always_comb begin
    nxt         = state;
    req_ready   = 2'b00;
    resp_valid  = 2'b00;
    rom_me      = 1'b0;
    rom_oe      = 1'b0;
    rom_address = '0;
    if (take) begin
      req_ready[grant] = 1'b1;
      rom_me           = legal;
      rom_address      = legal ? sel_addr[ROM_AW+1:2] : '0;
      nxt              = legal ? READ : RESP;
    end
    if (state == READ) begin
      rom_oe = 1'b1;
      nxt    = RESP;
    end
    if (state == RESP) begin
      resp_valid[owner] = 1'b1;
      nxt               = resp_ready[owner] ? IDLE : RESP;
    end
  end
  // state, owner and held response; illegal accesses skip the ROM and answer with an error
  always_ff @(posedge clock)
    if (reset) begin
      state     <= IDLE;
      owner     <= 1'b0;
      resp_data <= '0;
      resp_err  <= 1'b0;
    end else begin
      state <= nxt;
      if (take) begin
        owner <= grant;
        if (!legal) begin
          resp_data <= '0;
          resp_err  <= 1'b1;
        end
      end
      if (state == READ) begin
        resp_data <= rom_q;
        resp_err  <= 1'b0;
      end
    end
endmodule

// File: tb/tb_bootrom_arbiter.sv
// tb_bootrom_arbiter: directed and random transactions checked against a transaction-level model
module tb_bootrom_arbiter;
  localparam int WORDS = 1024;
  logic clock = 0, reset = 1;
  logic [1:0] req_valid = 0, req_ready, resp_valid, resp_ready = 0;
  logic [25:0] req_addr = 0;
  logic [31:0] resp_data, rom_q, q_reg = 0;
  logic resp_err, rom_me, rom_oe;
  logic [10:0] rom_address;
  logic [31:0] rom_img [2048];
  int errors = 0, checks = 0, ptr = 0;
  always #5 clock = ~clock;
  bootrom_arbiter #(.ROM_WORDS(WORDS)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_err(resp_err), .rom_me(rom_me), .rom_oe(rom_oe),
    .rom_address(rom_address), .rom_q(rom_q)
  );
  // behavioural BootROM: registered read, data visible only under oe
  always @(posedge clock) if (rom_me) q_reg <= rom_img[rom_address];
  assign rom_q = rom_oe ? q_reg : 32'hBAD0BAD0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic props();
    chk("me_oe_excl", 32'(rom_me & rom_oe), 0);
    chk("onehot_resp_valid", 32'($onehot0(resp_valid)), 1);
    chk("onehot_req_ready", 32'($onehot0(req_ready)), 1);
  endtask
  function automatic int pick(input logic [1:0] v);
    return v[ptr] ? ptr : 1 - ptr;
  endfunction
  // one transaction for port g, entered at the sample point of its grant cycle
  task automatic serve(input int g, input logic [12:0] a, input int bp);
    logic ok;
    logic [31:0] exp_data;
    ok = (a % 4 == 0) && (a / 4 < WORDS);
    exp_data = ok ? rom_img[a/4] : 0;
    chk("grant_ready", 32'(req_ready), 32'(1 << g));
    chk("grant_me", 32'(rom_me), 32'(ok));
    chk("grant_oe", 32'(rom_oe), 0);
    if (ok) chk("grant_addr", 32'(rom_address), 32'(a / 4));
    props();
    @(negedge clock);
    req_valid[g] = 1'b0;
    #1;
    if (ok) begin
      chk("read_oe", 32'(rom_oe), 1);
      chk("read_me", 32'(rom_me), 0);
      chk("read_ready", 32'(req_ready), 0);
      chk("read_valid", 32'(resp_valid), 0);
      props();
      @(negedge clock);
      #1;
    end
    for (int i = 0; i <= bp; i++) begin
      if (i > 0) begin
        @(negedge clock);
        #1;
      end
      resp_ready = (i == bp) ? 2'(1 << g) : 2'(1 << (1 - g));
      #1;
      chk("resp_valid", 32'(resp_valid), 32'(1 << g));
      chk("resp_data", resp_data, exp_data);
      chk("resp_err", 32'(resp_err), 32'(!ok));
      chk("resp_ready_block", 32'(req_ready), 0);
      chk("resp_me", 32'(rom_me), 0);
      props();
    end
    @(negedge clock);
    resp_ready = 0;
    #1;
    chk("after_accept_valid", 32'(resp_valid), 0);
    ptr = 1 - g;
  endtask
  task automatic go(input logic [1:0] v, input logic [12:0] a0, input logic [12:0] a1,
                    input int bp0, input int bp1);
    int g;
    @(negedge clock);
    req_valid = v;
    req_addr = {a1, a0};
    #1;
    for (int n = 0; n < 2 && req_valid != 0; n++) begin
      g = pick(req_valid);
      serve(g, g ? a1 : a0, g ? bp1 : bp0);
    end
  endtask
  task automatic reset_vals(input string tag);
    chk({tag, "_ready"}, 32'(req_ready), 0);
    chk({tag, "_valid"}, 32'(resp_valid), 0);
    chk({tag, "_err"}, 32'(resp_err), 0);
    chk({tag, "_data"}, resp_data, 0);
    chk({tag, "_me"}, 32'(rom_me), 0);
    chk({tag, "_oe"}, 32'(rom_oe), 0);
    chk({tag, "_addr"}, 32'(rom_address), 0);
  endtask
  initial begin
    for (int i = 0; i < 2048; i++) rom_img[i] = i * 32'h9E3779B1 ^ 32'h5A5A0000;
    rom_img[1] = 32'hDEADBEEF;
    req_valid = 2'b11;
    req_addr = {13'h0008, 13'h0000};
    repeat (3) @(negedge clock);
    #1;
    reset_vals("reset");
    @(negedge clock);
    reset = 0;
    #1;
    ptr = 0;
    for (int n = 0; n < 2 && req_valid != 0; n++) serve(pick(req_valid), pick(req_valid) ? 13'h0008 : 13'h0000, 0);
    go(2'b11, 13'h0010, 13'h0014, 0, 0);
    go(2'b01, 13'h0004, 13'h0000, 0, 0);
    go(2'b10, 13'h0000, 13'h0002, 0, 0);
    go(2'b01, 13'h1000, 13'h0000, 1, 0);
    go(2'b11, 13'h0020, 13'h0024, 5, 2);
    go(2'b11, 13'h0ffc, 13'h1ffc, 0, 0);
    @(negedge clock);
    req_valid = 2'b01;
    req_addr = {13'h0000, 13'h0040};
    #1;
    chk("rst_grant", 32'(req_ready), 32'(1 << pick(2'b01)));
    @(negedge clock);
    #1;
    chk("rst_in_read", 32'(rom_oe), 1);
    reset = 1;
    @(negedge clock);
    #1;
    reset_vals("midreset");
    reset = 0;
    ptr = 0;
    #1;
    serve(0, 13'h0040, 0);
    for (int k = 0; k < 24; k++) begin
      logic [1:0] v;
      logic [12:0] a [2];
      v = 2'($urandom_range(1, 3));
      for (int p = 0; p < 2; p++)
        case ($urandom_range(0, 3))
          0: a[p] = 13'($urandom_range(1, 8191));
          1: a[p] = 13'($urandom_range(1024, 2047) * 4);
          default: a[p] = 13'($urandom_range(0, 1023) * 4);
        endcase
      go(v, a[0], a[1], $urandom_range(0, 3), $urandom_range(0, 3));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
